// File: rtl/cpu16_pkg.sv
// Shared CPU16 definitions: instruction field layout, the opcodes the fetch
// front end cares about, and the fetch FSM state encoding.
package cpu16_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int IMM_W      = 16;

  localparam logic [OPCODE_W-1:0] OP_HALT = 6'b111111;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b110000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if
  import cpu16_pkg::*;
#(
  parameter int PC_W = 32
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_pc_adder.sv
// Next-PC computation: sequential pc+4, or pc+4 plus the sign-extended word
// offset from IR[15:0] when a branch is taken. Wraps modulo 2^PC_W.
module fetch_pc_adder
  import cpu16_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] imm,
  input  logic             pc_src,
  output logic [PC_W-1:0]  next_pc
);

  logic signed [IMM_W-1:0] imm_s;
  logic signed [PC_W-1:0]  imm_ext;
  logic signed [PC_W-1:0]  br_off;
  logic        [PC_W-1:0]  seq_pc;

  // Sign-extend the immediate, scale to a byte offset and select the target
  always_comb begin
    imm_s   = imm;
    imm_ext = PC_W'(imm_s);
    br_off  = imm_ext <<< 2;
    seq_pc  = pc + PC_W'(4);
    next_pc = pc_src ? (seq_pc + $unsigned(br_off)) : seq_pc;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// CPU16 instruction fetch unit: owns the PC, fetches over the imem req/ack
// bus, holds the instruction register and reacts to the control unit's
// PCWre/PCSrc. Optional macro FETCH_PERF_CNT_EN adds saturating executed-
// instruction and taken-branch counters.
module instr_fetch_unit
  import cpu16_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.master   imem,
  output logic [INSTR_W-1:0]   instr,
  output logic [OPCODE_W-1:0]  opcode,
  output logic                 instr_valid,
  output logic [PC_W-1:0]      pc,
  input  logic                 pc_wre,
  input  logic                 pc_src,
  output logic                 halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          instr_cnt,
  output logic [31:0]          br_taken_cnt
`endif
);

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic            run;
  logic            fetch_hit;
  logic            exec_adv;
  logic [PC_W-1:0] next_pc;

  fetch_pc_adder #(
    .PC_W (PC_W)
  ) u_pc_adder (
    .pc      (pc),
    .imm     (instr[IMM_W-1:0]),
    .pc_src  (pc_src),
    .next_pc (next_pc)
  );

  // The request only goes out once the first edge after reset release has
  // armed the unit, so an async reset drops imem_req immediately.
  assign imem.imem_req  = run && (state == FETCH);
  assign imem.imem_addr = pc;
  assign fetch_hit      = imem.imem_req && imem.imem_ack;
  assign exec_adv       = (state == EXEC) && pc_wre;
  assign instr_valid    = (state == EXEC);
  assign halted         = (state == HALT);
  assign opcode         = instr[OPCODE_MSB:OPCODE_LSB];

  // Arm flag: low throughout reset, high from the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next state: HALT wins over a taken branch, and HALT is absorbing
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:   if (fetch_hit) state_nxt = EXEC;
      EXEC:    state_nxt = pc_wre ? FETCH : HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // PC register: advances only on a non-halting EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= RESET_PC;
    else if (exec_adv) pc <= next_pc;
  end

  // Instruction register: captures only an ack that answers a live request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         instr <= '0;
    else if (fetch_hit) instr <= imem.imem_rdata;
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // Performance counters: executed instructions and taken branches, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt    <= '0;
      br_taken_cnt <= '0;
    end else begin
      if (state == EXEC)         instr_cnt    <= sat_inc(instr_cnt);
      if (exec_adv && pc_src)    br_taken_cnt <= sat_inc(br_taken_cnt);
    end
  end
`endif

endmodule
